alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that computes RV32M unsigned multiply and divide results using the core's shared 32-bit ripple-carry ALU (ALU32b) as its only adder. One ALU add or subtract runs per cycle: shift-add for multiply, restoring division for divide. The block sits beside the execute stage, owns the ALU control and operand lines while busy, and returns one 32-bit result through a valid/ready handshake.

---
 rtl/alu_muldiv_seq_pkg.sv | 32 +++
 rtl/alu_muldiv_seq_if.sv | 24 ++
 rtl/alu_muldiv_seq.sv | 102 ++++++++++
 tb/tb_alu_muldiv_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and constants for the shift-add / restoring-divide sequencer.
package alu_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef struct packed {
    logic m;
    logic s1;
    logic s0;
    logic cin;
  } alu_fn_t;

  localparam alu_fn_t ALU_ADD = 4'b0000;
  localparam alu_fn_t ALU_SUB = 4'b0011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_div(logic [1:0] op);
    return (op != OP_MUL) && (op != OP_MULHU);
  endfunction

  // MULHU and REMU both take their answer from the hi half of the working pair
  function automatic logic returns_hi(logic [1:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and the sequencer.
interface alu_muldiv_seq_if;
  import alu_seq_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// 32-cycle unsigned multiply/divide sequencer driving the shared external ALU,
// one add (multiply) or subtract (divide) per cycle.
module alu_muldiv_seq
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave bus,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_m,
  output logic            alu_s1,
  output logic            alu_s0,
  output logic            alu_cin,
  input  logic [XLEN-1:0] alu_f,
  input  logic            alu_cout
);

  state_t          state, state_nxt;
  logic [1:0]      op;
  logic [XLEN-1:0] hi, lo, opb;
  logic [XLEN-1:0] hi_nxt, lo_nxt, rem_sh;
  logic [XLEN:0]   sum_sel;
  logic [4:0]      cnt;
  logic            ge;
  logic [XLEN-1:0] rsp_data_q;
  alu_fn_t         fn;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign {alu_m, alu_s1, alu_s0, alu_cin} = fn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid)   state_nxt = RUN;
      RUN:     if (cnt == 5'd31)    state_nxt = DONE;
      DONE:    if (bus.rsp_ready)   state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // hi[31] set means the shifted partial remainder is >= 2^32, so it beats any divisor
  always_comb begin
    rem_sh  = {hi[XLEN-2:0], lo[XLEN-1]};
    ge      = alu_cout | hi[XLEN-1];
    sum_sel = lo[0] ? {alu_cout, alu_f} : {1'b0, hi};
    alu_a   = '0;
    alu_b   = '0;
    fn      = ALU_ADD;
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (state == RUN) begin
      alu_b = opb;
      if (is_div(op)) begin
        alu_a  = rem_sh;
        fn     = ALU_SUB;
        hi_nxt = ge ? alu_f : rem_sh;
        lo_nxt = {lo[XLEN-2:0], ge};
      end else begin
        alu_a  = hi;
        hi_nxt = sum_sel[XLEN:1];
        lo_nxt = {sum_sel[0], lo[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= OP_MUL;
      hi         <= '0;
      lo         <= '0;
      opb        <= '0;
      cnt        <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op  <= bus.req_op;
          hi  <= '0;
          lo  <= is_div(bus.req_op) ? bus.req_a : bus.req_b;
          opb <= is_div(bus.req_op) ? bus.req_b : bus.req_a;
          cnt <= '0;
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) rsp_data_q <= returns_hi(op) ? hi_nxt : lo_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: sequencer plus a behavioural ALU, scoreboarded against a reference model.
module tb_alu_muldiv_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_m, alu_s1, alu_s0, alu_cin, alu_cout;
  logic [32:0] alu_sum;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_muldiv_seq_if bus();

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_s1(alu_s1),
    .alu_s0(alu_s0), .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout)
  );

  assign alu_sum  = {1'b0, alu_a} + {1'b0, (alu_s0 ? ~alu_b : alu_b)} + {32'b0, alu_cin};
  assign alu_f    = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit noise,
                        output logic [31:0] got, output int lat, output bit tmo);
    int w;
    tmo = 0; w = 0; lat = 0; got = '0;
    exp_q.push_back(ref_model(op, a, b));
    while (!bus.req_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!bus.req_ready) begin tmo = 1; return; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 100) begin
      if (noise) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op = 2'($urandom_range(0, 3));
        bus.req_a = $urandom; bus.req_b = $urandom;
      end
      @(posedge clk); #1; lat++;
    end
    bus.req_valid = 1'b0;
    if (!bus.rsp_valid) begin tmo = 1; return; end
    repeat (stall) begin @(posedge clk); #1; end
    got = bus.rsp_data;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_hs ready=%b valid=%b data=%h want 1 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_data);
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || {alu_m, alu_s1, alu_s0, alu_cin} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_alu a=%h b=%h fn=%b want 0 0 0000", alu_a, alu_b, {alu_m, alu_s1, alu_s0, alu_cin});
    end
  endtask

  task automatic test_directed(input string name, input logic [1:0] ops[], input logic [31:0] as[],
                               input logic [31:0] bs[]);
    logic [31:0] got, exp; int lat; bit tmo;
    foreach (ops[i]) begin
      run_op(ops[i], as[i], bs[i], i % 3, 1'b0, got, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || got !== exp) begin
        errors++;
        $display("FAIL %s_data[%0d] op=%0d got=%h want=%h tmo=%0b", name, i, ops[i], got, exp, tmo);
      end
      checks++;
      if (lat !== 32) begin
        errors++;
        $display("FAIL %s_latency[%0d] got=%0d want=32", name, i, lat);
      end
    end
  endtask

  task automatic test_mul();
    logic [1:0]  ops[] = '{OP_MUL, OP_MULHU, OP_MUL};
    logic [31:0] as[]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[]  = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    test_directed("mul", ops, as, bs);
  endtask

  task automatic test_div();
    logic [1:0]  ops[] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
    logic [31:0] as[]  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] bs[]  = '{32'd7, 32'd7, 32'h8000_0001, 32'h8000_0001, 32'h0, 32'h0};
    test_directed("div", ops, as, bs);
  endtask

  task automatic test_ignore_inputs();
    logic [31:0] got, exp; int lat; bit tmo;
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b1, got, lat, tmo);
    exp = exp_q.pop_front();
    checks++;
    if (tmo || got !== exp || lat !== 32) begin
      errors++;
      $display("FAIL run_noise got=%h want=%h lat=%0d tmo=%0b", got, exp, lat, tmo);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, held; int lat; bit bad;
    bus.req_valid = 1'b1; bus.req_op = OP_MULHU; bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'h1234_5678;
    exp_q.push_back(ref_model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    exp = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || lat !== 32) begin
      errors++;
      $display("FAIL bp_first valid=%b data=%h want=%h lat=%0d", bus.rsp_valid, bus.rsp_data, exp, lat);
    end
    held = exp;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 5);
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0 ||
          alu_a !== 32'h0 || alu_b !== 32'h0 || alu_s0 !== 1'b0) bad = 1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold valid=%b data=%h want=%h ready=%b", bus.rsp_valid, bus.rsp_data, held, bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] got, exp; int lat; bit tmo, seen;
    bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_a = 32'h1234; bus.req_b = 32'h5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid ready=%b valid=%b data=%h want 1 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_data);
    end
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_rsp got rsp_valid=1 want 0");
    end
    run_op(OP_MUL, 32'd3, 32'd5, 0, 1'b0, got, lat, tmo);
    exp = exp_q.pop_front();
    checks++;
    if (tmo || got !== exp || lat !== 32) begin
      errors++;
      $display("FAIL rst_after got=%h want=%h lat=%0d", got, exp, lat);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] got, exp, a, b; logic [1:0] op; int lat; bit tmo;
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pick(); b = pick();
      run_op(op, a, b, $urandom_range(0, 3), n[0], got, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || got !== exp || lat !== 32) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h want=%h lat=%0d", n, op, a, b, got, exp, lat);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = OP_MUL; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_ignore_inputs();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
